// File: rtl/cook_timer_ctrl_pkg.sv
// cook_timer_ctrl_pkg: state encoding and default constants for the cook timer.
package cook_timer_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int DEF_TICKS_PER_SEC = 100;
    localparam int DEF_SEC_W         = 10;
    localparam int DEF_MAX_SEC       = 999;
    localparam int DEF_QUICK_SEC     = 30;
    localparam int DEF_BEEP_SEC      = 3;
endpackage

// File: rtl/cook_timer_ctrl_sec_tick_gen.sv
// sec_tick_gen: prescaler producing one tick every TICKS enabled cycles.
module sec_tick_gen #(
    parameter int TICKS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
    logic [W-1:0] r_cnt;
    assign tick = en & (r_cnt == W'(TICKS - 1));
    always_ff @(posedge clk) begin
        if (rst | clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: countdown cook timer driving the magnetron latch set/rst.
// Define COOK_BEEP_EN to hold DONE for BEEP_SEC seconds with a toggling beep.
module cook_timer_ctrl
    import cook_timer_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int SEC_W         = DEF_SEC_W,
    parameter int MAX_SEC       = DEF_MAX_SEC,
    parameter int QUICK_SEC     = DEF_QUICK_SEC
`ifdef COOK_BEEP_EN
    , parameter int BEEP_SEC    = DEF_BEEP_SEC
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             door_closed,
    input  logic             load,
    input  logic [SEC_W-1:0] load_sec,
    output logic             mag_set,
    output logic             mag_rst,
    output logic [SEC_W-1:0] remaining,
    output logic             done,
    output logic             beep
);
    state_t           r_state;
    logic [SEC_W-1:0] r_rem;
    logic             r_done;
    logic             w_tick;
    logic             w_done_end;
    logic             w_dopen;
    logic [SEC_W-1:0] w_load_val;

    assign w_dopen    = ~door_closed;
    assign w_load_val = (load_sec > SEC_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : load_sec;
    // Live door and reset gate the latch so an opening door cuts power this cycle.
    assign mag_set    = (r_state == COOK) & door_closed & ~rst;
    assign mag_rst    = ~mag_set;
    assign remaining  = r_rem;
    assign done       = r_done;

    sec_tick_gen #(.TICKS(TICKS_PER_SEC)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state == COOK),
        .clr  (r_state != COOK),
        .tick (w_tick)
    );

`ifdef COOK_BEEP_EN
    localparam int DONE_CYC = BEEP_SEC * TICKS_PER_SEC;
    localparam int DW       = $clog2(DONE_CYC + 1);
    logic [DW-1:0] r_dcnt;
    logic          r_beep;
    logic          w_half;
    sec_tick_gen #(.TICKS(TICKS_PER_SEC / 2)) u_beep (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state == DONE),
        .clr  (r_state != DONE),
        .tick (w_half)
    );
    assign w_done_end = r_dcnt == DW'(DONE_CYC - 1);
    assign beep       = r_beep & (r_state == DONE);
    always_ff @(posedge clk) begin
        if (rst || r_state != DONE) begin
            r_dcnt <= '0;
            r_beep <= 1'b0;
        end else begin
            r_dcnt <= r_dcnt + 1'b1;
            if (w_half)
                r_beep <= ~r_beep;
        end
    end
`else
    assign w_done_end = 1'b1;
    assign beep       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear)
                        r_rem <= '0;
                    else if (start & door_closed) begin
                        r_state <= COOK;
                        if (r_rem == '0)
                            r_rem <= SEC_W'(QUICK_SEC);
                    end else if (load)
                        r_rem <= w_load_val;
                end
                COOK: begin
                    if (clear) begin
                        r_state <= IDLE;
                        r_rem   <= '0;
                    end else if (w_dopen | stop)
                        r_state <= PAUSE;
                    else if (w_tick) begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == SEC_W'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (clear | stop) begin
                        r_state <= IDLE;
                        r_rem   <= '0;
                    end else if (start & door_closed)
                        r_state <= COOK;
                end
                DONE: begin
                    if (clear | start | w_dopen | w_done_end)
                        r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cook_timer_ctrl.sv
// tb_cook_timer_ctrl: directed scenarios plus randomized run against a reference model.
module tb_cook_timer_ctrl;
    localparam int T = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, door_closed = 1'b1, load = 1'b0;
    logic [9:0] load_sec = '0;
    logic       mag_set, mag_rst, done, beep;
    logic [9:0] remaining;
    int         n_tests = 0, n_fail = 0;

    // reference model: whole-seconds countdown with cycles elapsed in the current second
    bit m_cook, m_pause, m_done;
    int m_rem, m_sub;

    cook_timer_ctrl #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .door_closed(door_closed), .load(load), .load_sec(load_sec),
        .mag_set(mag_set), .mag_rst(mag_rst), .remaining(remaining),
        .done(done), .beep(beep)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
    endtask

    task automatic load_start(input int secs);
        door_closed = 1'b1;
        load = 1'b1;
        load_sec = 10'(secs);
        cyc();
        load = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        n_tests++;
        if (remaining !== 10'd0 || done !== 1'b0 || beep !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: remaining=%0d done=%b beep=%b, expected 0 0 0", remaining, done, beep);
        end
        n_tests++;
        if (mag_set !== 1'b0 || mag_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mag: set=%b rst=%b, expected 0 1", mag_set, mag_rst);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_load_cook;
        int n_set = 0, n_done = 0, done_at = -1;
        bit excl_bad = 0, seq_ok;
        int seq[$];
        int exp_seq[4] = '{3, 2, 1, 0};
        go_idle();
        load_start(3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (seq.size() == 0 || seq[$] != int'(remaining))
                seq.push_back(int'(remaining));
            n_set += int'(mag_set);
            if (done) begin
                n_done++;
                done_at = i;
            end
            if (mag_set === mag_rst)
                excl_bad = 1;
            cyc();
        end
        n_tests++;
        if (n_set != 12) begin
            n_fail++;
            $display("FAIL cook_mag_cycles: got %0d, expected 12", n_set);
        end
        seq_ok = seq.size() == 4;
        if (seq_ok)
            foreach (exp_seq[k]) if (seq[k] != exp_seq[k]) seq_ok = 0;
        n_tests++;
        if (!seq_ok) begin
            n_fail++;
            $display("FAIL cook_rem_seq: got %p, expected 3,2,1,0", seq);
        end
        n_tests++;
        if (n_done != 1 || done_at != 12) begin
            n_fail++;
            $display("FAIL cook_done: got %0d pulses at cycle %0d, expected 1 at 12", n_done, done_at);
        end
        n_tests++;
        if (excl_bad || mag_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL cook_mag_excl: overlap=%b final mag_rst=%b, expected 0 1", excl_bad, mag_rst);
        end
    endtask

    task automatic test_door_open;
        int n_set = 0, done_at = -1;
        go_idle();
        load_start(3);
        repeat (4) cyc();
        door_closed = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mag_set !== 1'b0 || mag_rst !== 1'b1 || remaining !== 10'd2) begin
            n_fail++;
            $display("FAIL door_same_cycle: set=%b rst=%b rem=%0d, expected 0 1 2", mag_set, mag_rst, remaining);
        end
        cyc();
        cyc();
        door_closed = 1'b1;
        cyc();
        @(negedge clk);
        n_tests++;
        if (mag_set !== 1'b0 || remaining !== 10'd2) begin
            n_fail++;
            $display("FAIL door_paused: set=%b rem=%0d, expected 0 2", mag_set, remaining);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_set += int'(mag_set);
            if (done && done_at < 0)
                done_at = i;
            cyc();
        end
        n_tests++;
        if (n_set != 8 || done_at != 8) begin
            n_fail++;
            $display("FAIL door_resume: got %0d cook cycles done at %0d, expected 8 at 8", n_set, done_at);
        end
    endtask

    task automatic test_double_stop;
        bit set_seen = 0;
        go_idle();
        load_start(5);
        repeat (2) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        @(negedge clk);
        n_tests++;
        if (remaining !== 10'd5 || mag_set !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_pause: rem=%0d set=%b, expected 5 0", remaining, mag_set);
        end
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mag_set)
                set_seen = 1;
            cyc();
        end
        n_tests++;
        if (remaining !== 10'd0 || set_seen) begin
            n_fail++;
            $display("FAIL stop_cancel: rem=%0d set_seen=%b, expected 0 0", remaining, set_seen);
        end
    endtask

    task automatic test_quick_clamp;
        int in_v[3] = '{1023, 1000, 998};
        int ex_v[3] = '{999, 999, 998};
        go_idle();
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (remaining !== 10'd30 || mag_set !== 1'b1) begin
            n_fail++;
            $display("FAIL quick_start: rem=%0d set=%b, expected 30 1", remaining, mag_set);
        end
        go_idle();
        foreach (in_v[k]) begin
            load = 1'b1;
            load_sec = 10'(in_v[k]);
            cyc();
            load = 1'b0;
            @(negedge clk);
            n_tests++;
            if (int'(remaining) != ex_v[k]) begin
                n_fail++;
                $display("FAIL clamp_%0d: rem=%0d, expected %0d", in_v[k], remaining, ex_v[k]);
            end
            cyc();
        end
    endtask

    task automatic test_simultaneous;
        go_idle();
        load_start(3);
        repeat (3) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        @(negedge clk);
        n_tests++;
        if (remaining !== 10'd3 || mag_set !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_on_tick: rem=%0d set=%b, expected 3 0", remaining, mag_set);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        n_tests++;
        if (remaining !== 10'd3) begin
            n_fail++;
            $display("FAIL resume_partial: rem=%0d, expected 3", remaining);
        end
        cyc();
        @(negedge clk);
        n_tests++;
        if (remaining !== 10'd2) begin
            n_fail++;
            $display("FAIL resume_first_tick: rem=%0d, expected 2", remaining);
        end
        go_idle();
        door_closed = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        door_closed = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mag_set !== 1'b0 || remaining !== 10'd0) begin
            n_fail++;
            $display("FAIL start_door_open: set=%b rem=%0d, expected 0 0", mag_set, remaining);
        end
    endtask

    task automatic test_reset_mid_cook;
        go_idle();
        load_start(7);
        repeat (8) cyc();
        @(negedge clk);
        n_tests++;
        if (remaining !== 10'd5 || mag_set !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_precond: rem=%0d set=%b, expected 5 1", remaining, mag_set);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (mag_set !== 1'b0 || mag_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_same_cycle: set=%b rst=%b, expected 0 1", mag_set, mag_rst);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (remaining !== 10'd0 || done !== 1'b0 || mag_set !== 1'b0 || mag_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after: rem=%0d done=%b set=%b rst=%b, expected 0 0 0 1",
                     remaining, done, mag_set, mag_rst);
        end
        cyc();
    endtask

    task automatic model_step;
        if (rst) begin
            m_cook = 0; m_pause = 0; m_done = 0; m_rem = 0; m_sub = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (clear) begin
            m_cook = 0; m_pause = 0; m_rem = 0;
        end else if (m_cook) begin
            if (!door_closed || stop) begin
                m_cook = 0; m_pause = 1;
            end else if (m_sub == T - 1) begin
                m_sub = 0;
                m_rem--;
                if (m_rem == 0) begin
                    m_cook = 0; m_done = 1;
                end
            end else
                m_sub++;
        end else if (m_pause) begin
            if (stop) begin
                m_pause = 0; m_rem = 0;
            end else if (start && door_closed) begin
                m_pause = 0; m_cook = 1; m_sub = 0;
            end
        end else if (start && door_closed) begin
            if (m_rem == 0) m_rem = 30;
            m_cook = 1; m_sub = 0;
        end else if (load)
            m_rem = (int'(load_sec) > 999) ? 999 : int'(load_sec);
    endtask

    task automatic test_random;
        bit exp_set;
        rst = 1'b1;
        model_step();
        cyc();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom % 250) == 0;
            clear       = ($urandom % 80) == 0;
            stop        = ($urandom % 50) == 0;
            start       = ($urandom % 6) == 0;
            door_closed = ($urandom % 30) != 0;
            load        = ($urandom % 10) == 0;
            load_sec    = (($urandom % 8) == 0) ? 10'($urandom % 1024) : 10'($urandom_range(1, 6));
            @(negedge clk);
            exp_set = m_cook && door_closed && !rst;
            n_tests++;
            if (int'(remaining) != m_rem || done !== m_done) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL rand_state[%0d]: rem=%0d done=%b, expected %0d %b", i, remaining, done, m_rem, m_done);
            end
            n_tests++;
            if (mag_set !== exp_set || mag_rst !== !exp_set || beep !== 1'b0) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL rand_mag[%0d]: set=%b rst=%b beep=%b, expected %b %b 0",
                             i, mag_set, mag_rst, beep, exp_set, !exp_set);
            end
            model_step();
            cyc();
        end
        rst = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0; load = 1'b0; door_closed = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_cook();
        test_door_open();
        test_double_stop();
        test_quick_clamp();
        test_simultaneous();
        test_reset_mid_cook();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
